mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage load/store unit for the pipelined RV32I core. It consumes the MemRead/MemWrite controls produced by the register-stage main decoder, along with funct3, the ALU address and the store data. It runs a request/acknowledge transaction on the data-memory bus and stalls the pipeline until that transaction completes. It also forms byte enables, extracts and sign- or zero-extends load data, and flags misaligned, illegal or timed-out accesses.

## Interface
- TIMEOUT, 255: maximum cycles spent in REQ waiting for bus_ack before a bus fault is raised; legal range 1..255.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MemRead  in  1  load request from the decoder.
- MemWrite  in  1  store request from the decoder; wins if both are asserted.
- funct3  in  3  access size and sign.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- addr  in  32  byte address from the ALU.
- wdata  in  32  store data, rs2 value.
- stall  out  1  holds the upstream pipeline while an access is in flight.
- load_data  out  32  extended load result; valid only in the DONE cycle of a load.
- misaligned  out  1  combinational pulse in IDLE for a misaligned access or an illegal funct3.
- bus_fault  out  1  high in the DONE cycle of an access that timed out.
- bus_req  out  1  bus request, registered.
- bus_we  out  1  1 = write, registered.
- bus_addr  out  32  {addr[31:2], 2'b00}, registered.
- bus_wdata  out  32  lane-replicated store data, registered.
- bus_be  out  4  byte enables, registered; 4'b0000 on reads.
- bus_ack  in  1  one-cycle completion strobe from memory.
- bus_rdata  in  32  read data; valid when bus_ack=1.

## Operation
- **State machine:** three states, IDLE, REQ and DONE.
- **IDLE with an access present** (MemRead|MemWrite):
  - If the access is legal and aligned: stall=1, the bus registers are loaded, and the FSM moves to REQ.
  - If misaligned or illegal: misaligned=1, stall=0, no bus access, and the FSM stays in IDLE.
- **Alignment rules:**
  - Halfword accesses require addr[0]=0.
  - Word accesses require addr[1:0]=00.
  - Any funct3 not listed for the operation is illegal.
- **REQ:** bus_req=1 and stall=1.
  - All bus_* outputs stay stable until bus_ack.
  - The wait counter increments every REQ cycle.
  - On bus_ack: a load captures its extended result, and the FSM moves to DONE.
  - If the counter reaches TIMEOUT with no ack: bus_req drops, a bus fault is latched, load_data is set to 0, and the FSM moves to DONE.
  - Both the completion and timeout transitions also clear bus_req.
- **DONE:** stall=0 for exactly one cycle.
  - load_data and bus_fault are valid; the pipeline advances.
  - The FSM always returns to IDLE, and the next access is not sampled until IDLE.
- **Store formatting:**
  - SB: bus_wdata is {4{wdata[7:0]}} and bus_be is 4'b0001<<addr[1:0].
  - SH: bus_wdata is {2{wdata[15:0]}} and bus_be is 4'b0011<<addr[1:0].
  - SW: bus_wdata is wdata and bus_be is 4'b1111.
- **Load extraction:**
  - Byte loads select lane addr[1:0] of bus_rdata.
  - Halfword loads select half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW passes bus_rdata through.
- The addr, funct3 and operation type used for extraction are the values captured on entry to REQ, not the live inputs.

## Timing
- **Reset values:**
  - FSM in IDLE, wait counter 0.
  - bus_req, bus_we, bus_be, bus_addr, bus_wdata, load_data and bus_fault all 0.
  - stall and misaligned are 0 when no access is presented.
- **Reset asserted mid-transaction:** bus_req drops immediately (asynchronously) and the FSM returns to IDLE. No DONE cycle is produced.
- **Minimum latency** (access presented in cycle 0):
  - Cycle 1: REQ, with bus_ack arriving in the same cycle.
  - Cycle 2: DONE.
  - stall is high in cycles 0 and 1 only.
- **General latency:** an ack after N REQ cycles gives stall=1 for N+1 cycles.
- **Timeout:** with no ack, bus_req stays high for exactly TIMEOUT cycles; bus_fault is high in the following cycle.
- **Ignored ack:** a bus_ack arriving in IDLE or DONE has no effect.
- **Simultaneous ack and timeout:** if bus_ack arrives in the cycle the counter hits TIMEOUT, the ack wins and bus_fault=0.

## Test plan
- **LW:** addr=0x100, bus_ack in the first REQ cycle, bus_rdata=0xDEADBEEF -> bus_addr=0x100 and bus_be=0000; stall high for 2 cycles; DONE shows load_data=0xDEADBEEF.
- **LB and LBU:** addr=0x103, bus_rdata=0x80FF7F01 -> LB gives 0xFFFFFF80; LBU gives 0x00000080.
- **SH:** addr=0x202, wdata=0x1234ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x200.
- **Misaligned:** LW at addr=0x101 -> misaligned=1 for one cycle; bus_req never asserted; stall=0.
- **Timeout:** TIMEOUT=4, LW with no ack -> bus_req high for 4 cycles; then DONE with bus_fault=1 and load_data=0.
- **Reset mid-access:** SW with ack withheld; rst_n pulled low during REQ -> bus_req=0 immediately; after release the FSM is in IDLE and stall=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: bus request/acknowledge sequencing,
// byte-lane formatting of stores and extraction/extension of loads.
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        misaligned,
   output logic        bus_fault,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  cnt;
   logic [2:0]  c_f3;
   logic [1:0]  c_lo;
   logic        c_ld;
   logic        access;
   logic        legal;
   logic        aligned;
   logic        start;
   logic        finish;
   logic        tmo;
   logic [31:0] st_wdata;
   logic [3:0]  st_be;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   assign access = MemRead | MemWrite;

   // Stores only accept 000/001/010; loads also accept the unsigned forms.
   always_comb begin
      legal   = 1'b0;
      aligned = 1'b0;
      case (funct3)
         3'b000: begin
            legal   = 1'b1;
            aligned = 1'b1;
         end
         3'b001: begin
            legal   = 1'b1;
            aligned = ~addr[0];
         end
         3'b010: begin
            legal   = 1'b1;
            aligned = (addr[1:0] == 2'b00);
         end
         3'b100: begin
            legal   = ~MemWrite;
            aligned = 1'b1;
         end
         3'b101: begin
            legal   = ~MemWrite;
            aligned = ~addr[0];
         end
         default: begin
            legal   = 1'b0;
            aligned = 1'b0;
         end
      endcase
   end

   always_comb begin
      st_wdata = wdata;
      st_be    = 4'b1111;
      case (funct3[1:0])
         2'b00: begin
            st_wdata = {4{wdata[7:0]}};
            st_be    = 4'b0001 << addr[1:0];
         end
         2'b01: begin
            st_wdata = {2{wdata[15:0]}};
            st_be    = 4'b0011 << addr[1:0];
         end
         default: begin
            st_wdata = wdata;
            st_be    = 4'b1111;
         end
      endcase
   end

   // Extraction uses the size/offset captured on entry to REQ.
   always_comb begin
      ld_byte = bus_rdata[{c_lo, 3'b000} +: 8];
      ld_half = c_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (c_f3)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_ext = {24'b0, ld_byte};
         3'b101:  ld_ext = {16'b0, ld_half};
         default: ld_ext = bus_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      stall      = 1'b0;
      misaligned = 1'b0;
      start      = 1'b0;
      finish     = 1'b0;
      tmo        = 1'b0;
      unique case (state)
         IDLE: begin
            if (access) begin
               if (legal && aligned) begin
                  stall     = 1'b1;
                  start     = 1'b1;
                  state_nxt = REQ;
               end else begin
                  misaligned = 1'b1;
               end
            end
         end
         REQ: begin
            stall = 1'b1;
            if (bus_ack) begin
               finish    = 1'b1;
               state_nxt = DONE;
            end else if (cnt == TMO_LAST) begin
               tmo       = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= 8'd0;
         c_f3      <= 3'd0;
         c_lo      <= 2'd0;
         c_ld      <= 1'b0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'd0;
         bus_wdata <= 32'd0;
         bus_be    <= 4'd0;
         load_data <= 32'd0;
         bus_fault <= 1'b0;
      end else begin
         bus_fault <= tmo;
         if (start) begin
            cnt       <= 8'd0;
            c_f3      <= funct3;
            c_lo      <= addr[1:0];
            c_ld      <= ~MemWrite;
            bus_req   <= 1'b1;
            bus_we    <= MemWrite;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_wdata <= MemWrite ? st_wdata : 32'd0;
            bus_be    <= MemWrite ? st_be : 4'b0000;
         end else if (state == REQ) begin
            cnt <= cnt + 8'd1;
         end
         if (finish) begin
            bus_req <= 1'b0;
            if (c_ld) begin
               load_data <= ld_ext;
            end
         end
         if (tmo) begin
            bus_req   <= 1'b0;
            load_data <= 32'd0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: transaction-level expectations
// checked every cycle, plus literal spot checks.
module tb_mem_access_unit;

   localparam int TMO = 4;

   logic        clk;
   logic        rst_n;
   logic        MemRead;
   logic        MemWrite;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic [31:0] load_data;
   logic        misaligned;
   logic        bus_fault;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   mem_access_unit #(.TIMEOUT(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .funct3     (funct3),
      .addr       (addr),
      .wdata      (wdata),
      .stall      (stall),
      .load_data  (load_data),
      .misaligned (misaligned),
      .bus_fault  (bus_fault),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_be     (bus_be),
      .bus_ack    (bus_ack),
      .bus_rdata  (bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   logic        chk_en = 1'b0;
   logic        e_stall = 1'b0;
   logic        e_mis = 1'b0;
   logic        e_req = 1'b0;
   logic        e_done = 1'b0;
   logic        e_we = 1'b0;
   logic [31:0] e_addr = '0;
   logic [3:0]  e_be = '0;
   logic [31:0] e_wd = '0;
   logic        e_fault = 1'b0;
   logic        e_ld_chk = 1'b0;
   logic [31:0] e_ld = '0;

   int          stall_cnt = 0;
   int          req_cnt = 0;
   int          mis_cnt = 0;
   logic        snap_we = 1'b0;
   logic [31:0] snap_addr = '0;
   logic [3:0]  snap_be = '0;
   logic [31:0] snap_wd = '0;
   logic [31:0] snap_ld = '0;
   logic        snap_fault = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic acc_ok(input logic st, input logic [2:0] f3,
                                   input logic [31:0] a);
      bit legal;
      int sz;
      legal = st ? (f3 <= 3'd2)
                 : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      sz = 1 << f3[1:0];
      return legal && ((int'(a[1:0]) % sz) == 0);
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3,
                                       input logic [31:0] a);
      int sz;
      int off;
      logic [3:0] be;
      sz  = 1 << f3[1:0];
      off = int'(a[1:0]);
      be  = '0;
      for (int i = 0; i < 4; i++) be[i] = (i >= off && i < off + sz);
      return be;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                           input logic [31:0] wd);
      int sz;
      logic [31:0] w;
      sz = 1 << f3[1:0];
      w  = '0;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % sz) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] rd);
      longint one;
      longint v;
      int sz;
      int off;
      one = 1;
      sz  = 1 << f3[1:0];
      off = int'(a[1:0]);
      v   = longint'(rd >> (8 * off));
      if (sz < 4) begin
         v = v & ((one << (8 * sz)) - 1);
         if (!f3[2] && v >= (one << (8 * sz - 1))) v = v - (one << (8 * sz));
      end
      return v[31:0];
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall", {31'b0, stall}, {31'b0, e_stall});
         chk("misaligned", {31'b0, misaligned}, {31'b0, e_mis});
         chk("bus_req", {31'b0, bus_req}, {31'b0, e_req});
         if (e_req) begin
            chk("bus_we", {31'b0, bus_we}, {31'b0, e_we});
            chk("bus_addr", bus_addr, e_addr);
            chk("bus_be", {28'b0, bus_be}, {28'b0, e_be});
            if (e_we) chk("bus_wdata", bus_wdata, e_wd);
            snap_we   = bus_we;
            snap_addr = bus_addr;
            snap_be   = bus_be;
            snap_wd   = bus_wdata;
         end
         if (e_done) begin
            chk("bus_fault", {31'b0, bus_fault}, {31'b0, e_fault});
            if (e_ld_chk) chk("load_data", load_data, e_ld);
            snap_ld    = load_data;
            snap_fault = bus_fault;
         end
         stall_cnt += int'(stall);
         req_cnt   += int'(bus_req);
         mis_cnt   += int'(misaligned);
      end
   end

   task automatic clr_cnt();
      stall_cnt = 0;
      req_cnt   = 0;
      mis_cnt   = 0;
   endtask

   task automatic idle(input int n, input logic ack);
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      bus_ack  = ack;
      e_stall  = 1'b0;
      e_mis    = 1'b0;
      e_req    = 1'b0;
      e_done   = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      bus_ack = 1'b0;
   endtask

   // n_ack: REQ cycle (1-based) carrying bus_ack; 0 = never acked.
   task automatic xact(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int n_ack, input logic [31:0] rdat,
                       input logic ack_done);
      logic st;
      logic ok;
      int k;
      st = wr;
      ok = (rd | wr) && acc_ok(st, f3, a);
      MemRead  = rd;
      MemWrite = wr;
      funct3   = f3;
      addr     = a;
      wdata    = wd;
      bus_ack  = 1'b0;
      e_stall  = ok;
      e_mis    = !ok;
      e_req    = 1'b0;
      e_done   = 1'b0;
      e_we     = st;
      e_addr   = {a[31:2], 2'b00};
      e_be     = st ? m_be(f3, a) : 4'b0000;
      e_wd     = m_wdata(f3, wd);
      @(posedge clk);
      #1;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      addr     = ~a;
      funct3   = ~f3;
      wdata    = ~wd;
      e_mis    = 1'b0;
      e_stall  = 1'b0;
      if (!ok) return;
      k = 0;
      do begin
         k++;
         e_req     = 1'b1;
         e_stall   = 1'b1;
         bus_ack   = (k == n_ack);
         bus_rdata = (k == n_ack) ? rdat : ~rdat;
         @(posedge clk);
         #1;
      end while (k != n_ack && k != TMO);
      bus_ack  = ack_done;
      e_req    = 1'b0;
      e_stall  = 1'b0;
      e_done   = 1'b1;
      e_fault  = (k != n_ack);
      e_ld_chk = !st || e_fault;
      e_ld     = e_fault ? 32'd0 : m_load(f3, a, rdat);
      @(posedge clk);
      #1;
      bus_ack = 1'b0;
      e_done  = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      funct3    = 3'd0;
      addr      = 32'd0;
      wdata     = 32'd0;
      bus_ack   = 1'b0;
      bus_rdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_req", {31'b0, bus_req}, 32'd0);
      chk("rst_we", {31'b0, bus_we}, 32'd0);
      chk("rst_be", {28'b0, bus_be}, 32'd0);
      chk("rst_addr", bus_addr, 32'd0);
      chk("rst_wdata", bus_wdata, 32'd0);
      chk("rst_ld", load_data, 32'd0);
      chk("rst_fault", {31'b0, bus_fault}, 32'd0);
      chk("rst_mis", {31'b0, misaligned}, 32'd0);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      chk_en = 1'b1;
      idle(2, 1'b1);

      clr_cnt();
      xact(1, 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF, 0);
      chk("lw_addr", snap_addr, 32'h100);
      chk("lw_be", {28'b0, snap_be}, 32'd0);
      chk("lw_stall", stall_cnt, 32'd2);
      chk("lw_data", snap_ld, 32'hDEADBEEF);

      xact(1, 0, 3'b000, 32'h103, 32'h0, 2, 32'h80FF7F01, 1);
      chk("lb_data", snap_ld, 32'hFFFFFF80);
      xact(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF7F01, 0);
      chk("lbu_data", snap_ld, 32'h00000080);

      xact(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 1, 32'h0, 0);
      chk("sh_we", {31'b0, snap_we}, 32'd1);
      chk("sh_be", {28'b0, snap_be}, 32'hC);
      chk("sh_wdata", snap_wd, 32'hABCDABCD);
      chk("sh_addr", snap_addr, 32'h200);

      clr_cnt();
      xact(1, 0, 3'b010, 32'h101, 32'h0, 1, 32'h0, 0);
      idle(2, 1'b0);
      chk("mis_cnt", mis_cnt, 32'd1);
      chk("mis_req", req_cnt, 32'd0);
      chk("mis_stall", stall_cnt, 32'd0);

      clr_cnt();
      xact(1, 0, 3'b010, 32'h40, 32'h0, 0, 32'h55AA55AA, 0);
      chk("tmo_req", req_cnt, TMO);
      chk("tmo_fault", {31'b0, snap_fault}, 32'd1);
      chk("tmo_ld", snap_ld, 32'd0);

      xact(1, 0, 3'b010, 32'h44, 32'h0, TMO, 32'h0BADF00D, 0);
      chk("race_fault", {31'b0, snap_fault}, 32'd0);
      chk("race_ld", snap_ld, 32'h0BADF00D);

      clr_cnt();
      xact(1, 0, 3'b001, 32'h104, 32'h0, 3, 32'h80017FFE, 0);
      chk("lh_lat", stall_cnt, 32'd4);
      chk("lh_data", snap_ld, 32'h00007FFE);
      xact(1, 0, 3'b001, 32'h106, 32'h0, 1, 32'h80017FFE, 0);
      chk("lh_neg", snap_ld, 32'hFFFF8001);
      xact(1, 0, 3'b101, 32'h106, 32'h0, 1, 32'h80017FFE, 0);
      chk("lhu_data", snap_ld, 32'h00008001);
      xact(0, 1, 3'b000, 32'h5, 32'h000000EF, 1, 32'h0, 0);
      chk("sb_be", {28'b0, snap_be}, 32'h2);
      chk("sb_wdata", snap_wd, 32'hEFEFEFEF);
      xact(0, 1, 3'b010, 32'h8, 32'hCAFEF00D, 2, 32'h0, 1);
      xact(1, 1, 3'b000, 32'h7, 32'h00000042, 1, 32'h0, 0);
      chk("both_we", {31'b0, snap_we}, 32'd1);
      chk("both_be", {28'b0, snap_be}, 32'h8);
      xact(1, 0, 3'b011, 32'h0, 32'h0, 1, 32'h0, 0);
      xact(0, 1, 3'b100, 32'h0, 32'h0, 1, 32'h0, 0);
      xact(0, 1, 3'b001, 32'h3, 32'h0, 1, 32'h0, 0);
      idle(2, 1'b1);

      MemWrite = 1'b1;
      funct3   = 3'b010;
      addr     = 32'h300;
      wdata    = 32'h11223344;
      e_stall  = 1'b1;
      e_we     = 1'b1;
      e_addr   = 32'h300;
      e_be     = 4'hF;
      e_wd     = 32'h11223344;
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
      e_req    = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      #2;
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("arst_req", {31'b0, bus_req}, 32'd0);
      chk("arst_stall", {31'b0, stall}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("post_stall", {31'b0, stall}, 32'd0);
      chk("post_req", {31'b0, bus_req}, 32'd0);
      e_req   = 1'b0;
      e_stall = 1'b0;
      chk_en  = 1'b1;
      idle(2, 1'b0);
      xact(1, 0, 3'b010, 32'h300, 32'h0, 1, 32'h12345678, 0);
      chk("post_ld", snap_ld, 32'h12345678);
      idle(2, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
